// File: rtl/data_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-ported data memory.
// Each request is held in a register until the memory completes it or the wait counter expires.
module data_mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ack,
  output logic              core_stall,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              aux_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              err
);

  localparam int unsigned CNT_W = 8;
  localparam logic        GNT_CORE = 1'b0;
  localparam logic        GNT_AUX  = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t              r_state;
  logic                r_last_grant;
  logic                r_gnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_core_rdata;
  logic [DATA_W-1:0]   r_aux_rdata;
  logic                r_core_ack;
  logic                r_aux_ack;
  logic                r_mem_en;
  logic                r_mem_we;
  logic                r_err;

  logic                w_gnt;
  logic                w_timeout;

  // Round-robin pick: on a tie the requester that did not win last time gets the grant.
  always_comb begin
    w_gnt = GNT_CORE;
    if (core_req && aux_req) begin
      w_gnt = ~r_last_grant;
    end else if (aux_req) begin
      w_gnt = GNT_AUX;
    end
  end

  // The wait counter expires on the BUSY cycle that would bring it up to TIMEOUT.
  assign w_timeout = ((r_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= GNT_AUX;
      r_gnt        <= GNT_CORE;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_core_rdata <= '0;
      r_aux_rdata  <= '0;
      r_core_ack   <= 1'b0;
      r_aux_ack    <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_core_ack <= 1'b0;
      r_aux_ack  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (core_req || aux_req) begin
            r_gnt        <= w_gnt;
            r_last_grant <= w_gnt;
            r_we         <= (w_gnt == GNT_AUX) ? aux_we    : core_we;
            r_addr       <= (w_gnt == GNT_AUX) ? aux_addr  : core_addr;
            r_wdata      <= (w_gnt == GNT_AUX) ? aux_wdata : core_wdata;
            r_mem_we     <= (w_gnt == GNT_AUX) ? aux_we    : core_we;
            r_mem_en     <= 1'b1;
            r_cnt        <= '0;
            r_state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mem_valid || w_timeout) begin
            // A memory completion on the expiry cycle takes priority over the timeout.
            if (!r_we) begin
              if (r_gnt == GNT_AUX) begin
                r_aux_rdata <= mem_valid ? mem_rdata : '0;
              end else begin
                r_core_rdata <= mem_valid ? mem_rdata : '0;
              end
            end
            if (!mem_valid) begin
              r_err <= 1'b1;
            end
            r_core_ack <= (r_gnt == GNT_CORE);
            r_aux_ack  <= (r_gnt == GNT_AUX);
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_state    <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state  <= S_IDLE;
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
        end
      endcase
    end
  end

  assign core_rdata = r_core_rdata;
  assign aux_rdata  = r_aux_rdata;
  assign core_ack   = r_core_ack;
  assign aux_ack    = r_aux_ack;
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign err        = r_err;
  assign core_stall = core_req & ~r_core_ack;

endmodule
